// File: rtl/vedic_seq_mul_ctrl_pkg.sv
// Shared types and constants for the sequential Vedic multiplier controller.
package vedic_seq_mul_ctrl_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width and the digit/cycle counts it implies
  localparam int unsigned DEF_W  = 8;
  localparam int unsigned DIGITS = DEF_W / 2;
  localparam int unsigned CYCLES = DIGITS * DIGITS;

endpackage

// File: rtl/vedic_seq_mul_ctrl_cell.sv
// 2x2 Vedic (Urdhva Tiryakbhyam) multiplier cell, purely combinational.
module VedicMil2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] c
);

  logic cross_carry;

  // Vertical and crosswise partial products combined with half adders
  assign c[0]        = a[0] & b[0];
  assign c[1]        = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign cross_carry = (a[1] & b[0]) & (a[0] & b[1]);
  assign c[2]        = (a[1] & b[1]) ^ cross_carry;
  assign c[3]        = (a[1] & b[1]) & cross_carry;

endmodule

// File: rtl/vedic_seq_mul_ctrl.sv
// Sequential W x W multiplier: one 2x2 Vedic cell walks every digit pair,
// one pair per cycle, shifting each cell product into a 2W-bit accumulator.
module vedic_seq_mul_ctrl
  import vedic_seq_mul_ctrl_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int unsigned PW    = 2 * W;
  localparam int unsigned N_DIG = W / 2;
  localparam int unsigned DW    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned CW    = 2 * DW;
  localparam int unsigned SW    = DW + 2;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dig_i;
  logic [DW-1:0] dig_j;
  logic [1:0]    a_dig;
  logic [1:0]    b_dig;
  logic [3:0]    cell_p;
  logic [SW-1:0] sh;
  logic [PW-1:0] term;
  logic          last_i;
  logic          last_pair;

  // Digit selection: low half of cnt picks the a-digit, high half the b-digit
  assign dig_i = cnt[DW-1:0];
  assign dig_j = cnt[CW-1:DW];
  assign a_dig = 2'(a_q >> {dig_i, 1'b0});
  assign b_dig = 2'(b_q >> {dig_j, 1'b0});

  VedicMil2bit u_cell (
    .a (a_dig),
    .b (b_dig),
    .c (cell_p)
  );

  // Weight of the current pair is 4^(i+j); sum stays well inside 2W bits
  assign sh        = SW'({dig_i, 1'b0}) + SW'({dig_j, 1'b0});
  assign term      = PW'(cell_p) << sh;
  assign last_i    = (dig_i == DW'(N_DIG - 1));
  assign last_pair = last_i && (dig_j == DW'(N_DIG - 1));

  // Controller FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      p         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            cnt      <= '0;
            p        <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          p <= p + term;
          // Wrap the a-digit explicitly so non-power-of-two digit counts work
          cnt <= last_i ? {dig_j + DW'(1), DW'(0)} : cnt + CW'(1);
          if (last_pair) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
